// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset address and fetch-entry record for the instruction fetch stage.
package fetch_queue_pkg;

    localparam int FQ_ADDR_W = 10;
    localparam int FQ_INSTR_W = 16;
    localparam int FQ_DEPTH = 4;
    localparam int unsigned FQ_RESET_PC = 0;

    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Next sequential fetch address; wraps at the top of the ROM.
    function automatic logic [FQ_ADDR_W-1:0] fq_next_pc(input logic [FQ_ADDR_W-1:0] pc);
        return pc + FQ_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch circular buffer: read/write pointers, occupancy count, synchronous flush.
import fetch_queue_pkg::*;

module fetch_fifo #(
    parameter int WIDTH = FQ_INSTR_W + FQ_ADDR_W,
    parameter int DEPTH = FQ_DEPTH,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign full       = (count == (PW+1)'(DEPTH));
    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, ROM issue, squash/redirect and prefetch FIFO to the decoder.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
import fetch_queue_pkg::*;

module fetch_queue #(
    parameter int          ADDR_W   = FQ_ADDR_W,
    parameter int          INSTR_W  = FQ_INSTR_W,
    parameter int          DEPTH    = FQ_DEPTH,
    parameter int unsigned RESET_PC = FQ_RESET_PC
) (
    input  logic               clk,
    input  logic               Reset,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              squash;

    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              fifo_valid;
    logic [EW-1:0]     head_data;
    logic              resp;
    logic              push;
    logic              pop;

    // Occupancy counts the outstanding request; a same-cycle pop earns no credit.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign rom_en    = Reset && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign rom_addr  = fetch_pc;
    assign resp      = inflight && !squash;
    assign pop       = fifo_valid && instr_ready;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass      = resp && !redirect && !fifo_valid;
    assign push        = resp && !(bypass && instr_ready);
    assign instr_valid = fifo_valid || bypass;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (fifo_valid) begin
            instr    = head_data[EW-1:ADDR_W];
            instr_pc = head_data[ADDR_W-1:0];
        end else if (bypass) begin
            instr    = rom_data;
            instr_pc = inflight_pc;
        end
    end
`else
    assign push        = resp;
    assign instr_valid = fifo_valid;
    assign instr       = fifo_valid ? head_data[EW-1:ADDR_W] : '0;
    assign instr_pc    = fifo_valid ? head_data[ADDR_W-1:0]  : '0;
`endif

    always_ff @(posedge clk) begin
        if (!Reset) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            squash      <= 1'b0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                inflight_pc <= fetch_pc;
            end
            // Squash covers exactly the response slot following the redirect.
            squash <= redirect && inflight;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (rom_en) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .Reset      (Reset),
        .flush      (redirect),
        .push       (push),
        .push_data  ({rom_data, inflight_pc}),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (head_data),
        .count      (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
import fetch_queue_pkg::*;

module tb_fetch_queue;

    localparam int AW = FQ_ADDR_W;
    localparam int IW = FQ_INSTR_W;
    localparam int D  = FQ_DEPTH;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          Reset;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_en_cyc;
    int first_valid_cyc;

    fetch_entry_t  m_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_inflight_pc;
    bit            m_inflight;
    logic          s_en;
    logic [AW-1:0] s_addr;
    logic [AW-1:0] acc_q[$];

    fetch_queue dut (
        .clk         (clk),
        .Reset       (Reset),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
        return IW'(32'h1000 + 32'(a));
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_bypass();
`ifdef FETCH_BYPASS_EN
        return (m_q.size() == 0) && m_inflight && !redirect;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: compare at negedge, advance the model at posedge, then answer the ROM read.
    task automatic step();
        bit           e_en;
        bit           e_val;
        bit           byp;
        fetch_entry_t e_head;
        @(negedge clk);
        e_en = Reset && !redirect && ((m_q.size() + int'(m_inflight)) < D);
        check_val("rom_en", 32'(rom_en), 32'(e_en));
        if (e_en) check_val("rom_addr", 32'(rom_addr), 32'(m_pc));
        e_head = '0;
        e_val  = 1'b0;
        byp    = exp_bypass();
        if (m_q.size() > 0) begin
            e_val  = 1'b1;
            e_head = m_q[0];
        end else if (byp) begin
            e_val        = 1'b1;
            e_head.instr = rom_word(m_inflight_pc);
            e_head.pc    = m_inflight_pc;
        end
        check_val("instr_valid", 32'(instr_valid), 32'(e_val));
        check_val("instr", 32'(instr), 32'(e_head.instr));
        check_val("instr_pc", 32'(instr_pc), 32'(e_head.pc));
        if (rom_en === 1'b1 && first_en_cyc < 0) first_en_cyc = cyc;
        if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (instr_valid === 1'b1 && instr_ready && !redirect && Reset) acc_q.push_back(instr_pc);
        s_en   = rom_en;
        s_addr = rom_addr;
        @(posedge clk);
        if (!Reset) begin
            m_q.delete();
            m_pc       = AW'(FQ_RESET_PC);
            m_inflight = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_pc       = redirect_pc;
            m_inflight = 1'b0;
        end else begin
            if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
            if (m_inflight && !(byp && instr_ready))
                m_q.push_back('{instr: rom_word(m_inflight_pc), pc: m_inflight_pc});
            if (e_en) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_pc;
                m_pc          = m_pc + AW'(1);
            end else begin
                m_inflight = 1'b0;
            end
        end
        cyc++;
        #1;
        rom_data = (s_en === 1'b1) ? rom_word(s_addr) : 16'hDEAD;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b0;
        run(n);
        Reset = 1'b1;
        first_en_cyc    = -1;
        first_valid_cyc = -1;
        acc_q.delete();
    endtask

    // Stall the decoder until the model shows a stated FIFO fill with a request outstanding.
    task automatic wait_fill(input string tag, input int want);
        bit hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_q.size() == want && m_inflight) hit = 1'b1;
            else step();
        end
        check_val(tag, 32'(hit), 32'd1);
    endtask

    task automatic check_acc(input string tag, input int idx, input logic [AW-1:0] exp);
        if (acc_q.size() > idx) check_val(tag, 32'(acc_q[idx]), 32'(exp));
        else check_val({tag, "_missing"}, 32'(acc_q.size()), 32'(idx + 1));
    endtask

    initial begin
        int rcyc;
        Reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        rom_data    = 16'hDEAD;
        m_pc        = AW'(FQ_RESET_PC);
        m_inflight  = 1'b0;
        m_inflight_pc = '0;
        first_en_cyc    = -1;
        first_valid_cyc = -1;
        @(posedge clk);
        #1;

        // Straight-line streaming from reset
        do_reset(2);
        run(12);
        check_val("load_to_use", 32'(first_valid_cyc - first_en_cyc), 32'(LAT));
        for (int k = 0; k < 6; k++) check_acc("stream_pc", k, AW'(k));

        // Decoder stall from reset, then drain
        do_reset(2);
        instr_ready = 1'b0;
        run(10);
        @(negedge clk);
        check_val("stall_rom_en", 32'(rom_en), 32'd0);
        check_val("stall_head", 32'(instr), 32'h1000);
        check_val("stall_head_pc", 32'(instr_pc), 32'd0);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        run(10);
        for (int k = 0; k < 7; k++) check_acc("drain_pc", k, AW'(k));

        // Redirect with three buffered words and one in flight
        instr_ready = 1'b0;
        wait_fill("wait_fill3", 3);
        redirect    = 1'b1;
        redirect_pc = AW'(10'h200);
        instr_ready = 1'b1;
        rcyc = cyc;
        step();
        redirect = 1'b0;
        acc_q.delete();
        first_valid_cyc = -1;
        run(6);
        check_val("redirect_latency", 32'(first_valid_cyc - rcyc), 32'(LAT + 1));
        check_acc("redirect_pc0", 0, AW'(10'h200));
        check_acc("redirect_pc1", 1, AW'(10'h201));

        // Address wrap at the top of the ROM
        redirect    = 1'b1;
        redirect_pc = AW'(10'h3FE);
        step();
        redirect = 1'b0;
        acc_q.delete();
        run(8);
        check_acc("wrap_pc0", 0, AW'(10'h3FE));
        check_acc("wrap_pc1", 1, AW'(10'h3FF));
        check_acc("wrap_pc2", 2, AW'(10'h000));
        check_acc("wrap_pc3", 3, AW'(10'h001));

        // Reset mid-stream with buffered words and a request in flight
        instr_ready = 1'b0;
        wait_fill("wait_fill2", 2);
        Reset = 1'b0;
        step();
        @(negedge clk);
        check_val("rst_rom_en", 32'(rom_en), 32'd0);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_instr", 32'(instr), 32'd0);
        check_val("rst_pc", 32'(instr_pc), 32'd0);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        instr_ready = 1'b1;
        acc_q.delete();
        run(8);
        check_acc("rst_restart0", 0, AW'(FQ_RESET_PC));
        check_acc("rst_restart1", 1, AW'(FQ_RESET_PC + 1));

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = AW'($urandom);
            Reset       = ($urandom_range(0, 59) != 0);
            step();
        end
        Reset    = 1'b1;
        redirect = 1'b0;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting between the program ROM and the instruction decoder inside `uP`. It owns the program counter and issues one ROM read per cycle while buffer space is available. Returned instruction words are held in a small prefetch FIFO and presented to the decoder over a valid/ready handshake. A redirect input, driven by branch/jump resolution, flushes the buffer and restarts fetch at a new address.

## Interface
- `ADDR_W`, default 10: ROM word-address width.
- `INSTR_W`, default 16: instruction word width.
- `DEPTH`, default 4: prefetch FIFO entries; must be a power of two, at least 2.
- `RESET_PC`, default 0: fetch address after reset.

- `clk`, in, 1: single clock; all state updates on its rising edge.
- `Reset`, in, 1: synchronous, active-low reset.
- `rom_en`, out, 1: ROM read request this cycle.
- `rom_addr`, out, ADDR_W: ROM read address; meaningful only while `rom_en`=1.
- `rom_data`, in, INSTR_W: ROM word, valid exactly 1 cycle after the `rom_en` cycle.
- `redirect`, in, 1: flush and restart fetch.
- `redirect_pc`, in, ADDR_W: new fetch address, sampled when `redirect`=1.
- `instr_valid`, out, 1: head entry available to the decoder.
- `instr_ready`, in, 1: decoder accepts the head entry.
- `instr`, out, INSTR_W: head instruction word; 0 when `instr_valid`=0.
- `instr_pc`, out, ADDR_W: address of the head instruction; 0 when `instr_valid`=0.

## Operation
- State:
  - `fetch_pc`: next address to issue.
  - `inflight` (1 bit): a request was issued last cycle.
  - `inflight_pc`: address of that request.
  - `squash` (1 bit): drop the next response.
  - FIFO `count`, 0..DEPTH.
- Issue: `rom_en` = `Reset` && !`redirect` && (`count` + `inflight`) < DEPTH.
  - No credit is taken for a same-cycle pop.
  - On issue: `rom_addr` = `fetch_pc`; `fetch_pc` <= `fetch_pc`+1, modulo 2^ADDR_W (2^ADDR_W−1 wraps to 0).
- Response: when `inflight`=1 and `squash`=0, push {`rom_data`, `inflight_pc`} into the FIFO. A squashed response is discarded.
- Pop: when `instr_valid` && `instr_ready`, advance the FIFO head. Push and pop may occur in the same cycle, leaving `count` unchanged.
- Redirect (highest priority):
  - FIFO `count` <= 0; the pop and push of that cycle are ignored.
  - `fetch_pc` <= `redirect_pc`.
  - `squash` <= `inflight`; no issue that cycle.
  - Back-to-back redirects: the last one wins.
- FIFO full: issue is blocked by the occupancy rule, so a push to a full FIFO cannot occur. An implementation that would overflow is a bug, and the bench checks for it.
- Reset (`Reset`=0 at a rising edge), which also aborts any in-flight request mid-operation:
  - `fetch_pc`=RESET_PC.
  - `count`, `inflight`, `squash` = 0.
  - Outputs: `rom_en`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.

## Timing
- Request issued at cycle t: data arrives at t+1 and is written at the end of t+1; `instr_valid` rises at t+2 (load-to-use latency 2).
- Sustained throughput: 1 instruction/cycle while `instr_ready` stays 1.
- Redirect sampled at cycle t:
  - `instr_valid`=0 at t+1.
  - First issue at t+1 with `rom_addr`=`redirect_pc`.
  - First new instruction valid at t+3.
- First issue after reset release: the cycle after `Reset` is sampled high.
- `instr_valid` and the head outputs are registered. They must not depend combinationally on `instr_ready` (no bypass build).
- Decoder stall (`instr_ready`=0): the FIFO fills to DEPTH and `rom_en` stays low until a pop. Head outputs remain stable while stalled.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and an unsquashed response arrives, it is forwarded combinationally: `instr_valid`=1, `instr`=`rom_data`, `instr_pc`=`inflight_pc` in the response cycle (latency 1).
  - If `instr_ready`=1 in that cycle, the word is not written into the FIFO; otherwise it is pushed normally.
  - Redirect in the same cycle suppresses the bypass.
- Undefined: no bypass. Latency is exactly as in Timing, and all outputs come from registers.

## Structure
- Shared definitions package: `ADDR_W`/`INSTR_W` defaults, `RESET_PC`, the fetch-entry record {instr, pc}, and the FIFO depth constant.
- Sub-module `fetch_fifo`:
  - Circular buffer with read/write pointers, `count`, synchronous flush, `Reset` active-low synchronous.
  - Instantiated once.
- Issue, PC and squash logic stay in `fetch_queue`.

## Test plan
- Reset with `RESET_PC`=0, `instr_ready`=1, ROM word k = 0x1000+k → `rom_addr` 0,1,2,… on consecutive cycles; `instr`=0x1000,0x1001,… with matching `instr_pc`; first `instr_valid` 2 cycles after first `rom_en`.
- `instr_ready`=0 for 10 cycles → `count` reaches 4; `rom_en` low; head stays 0x1000/pc 0. Release → 4 buffered words drain in order, then fetch resumes at pc 4.
- `redirect`=1, `redirect_pc`=0x200 while a request is in flight and FIFO holds 3 → in-flight word dropped; `instr_valid`=0 next cycle; `rom_addr`=0x200 next cycle; first `instr_pc`=0x200 three cycles after redirect.
- `redirect_pc`=0x3FE with ADDR_W=10 → fetched pcs 0x3FE, 0x3FF, 0x000, 0x001.
- `Reset` pulled low mid-stream with FIFO non-empty and a request in flight → next cycle all outputs 0; after release, fetch restarts at `RESET_PC`; no stale word appears.
- With `FETCH_BYPASS_EN`: empty FIFO, `instr_ready`=1 → `instr_valid` in the same cycle as `rom_data`; redirect in that cycle → no bypass and no push.
